// File: rtl/shift_pkg.sv
// Shared types and default widths for the iterative shift units.
package shift_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_SHAMT_WIDTH = $clog2(DEFAULT_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shamt_down_counter.sv
// Loadable shift-amount down counter with a registered "count is one" flag.
module shamt_down_counter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_SHAMT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             is_one
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; is_one tracks the value being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      is_one <= 1'b0;
    end else if (load) begin
      count  <= load_value;
      is_one <= (load_value == WIDTH'(1));
    end else if (dec) begin
      count  <= count - WIDTH'(1);
      is_one <= (count == WIDTH'(2));
    end
  end

endmodule

// File: rtl/slli_iterative.sv
// Iterative logical left shift by immediate: one bit per cycle, valid/ready on both sides.
module slli_iterative
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] Immediate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Rd
);

  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);

  shift_state_e          state;
  logic [DATA_WIDTH-1:0] work;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                  accept_c;
  logic                  dec_c;
  logic                  cnt_is_one;
  logic                  unused_imm;

  // Only the low bits of the immediate select the shift amount.
  assign shamt      = Immediate[SHAMT_WIDTH-1:0];
  assign unused_imm = ^Immediate[DATA_WIDTH-1:SHAMT_WIDTH];

  // Counter strobes; flush suppresses both so it wins over acceptance and shifting.
  assign accept_c = (state == IDLE) && in_valid && !flush;
  assign dec_c    = (state == SHIFT) && !flush;

  shamt_down_counter #(
    .WIDTH (SHAMT_WIDTH)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept_c),
    .load_value (shamt),
    .dec        (dec_c),
    .is_one     (cnt_is_one)
  );

  assign Rd = work;

  // Control FSM and datapath; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= SrcA;
            in_ready <= 1'b0;
            if (shamt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= {work[DATA_WIDTH-2:0], 1'b0};
          if (cnt_is_one) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slli_iterative.sv
// Directed bench for slli_iterative with hand-computed results and latencies.
module tb_slli_iterative;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] Immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Rd;

  int n_checks;
  int n_fail;

  slli_iterative #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .Immediate (Immediate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Rd        (Rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents a request, waits for acceptance, then scrambles inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] imm);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("start_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    SrcA      = a;
    Immediate = imm;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    SrcA      = $urandom;
    Immediate = $urandom;
  endtask

  // Called at the negedge after acceptance; measures edges until out_valid and checks Rd.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_rd);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd"}, Rd, exp_rd);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
  endtask

  // Full transaction with out_ready held high; confirms return to IDLE one edge later.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] imm,
                        input int exp_lat, input logic [31:0] exp_rd);
    start_op(a, imm);
    wait_done(tag, exp_lat, exp_rd);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    SrcA      = '0;
    Immediate = '0;
    #23;
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rd", Rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic shifts, full-width shift, shamt=0 and ignored upper immediate bits.
    run_op("sh2", 32'h0000_0010, 32'h0000_0002, 2, 32'h0000_0040);
    run_op("sh31", 32'h0000_0001, 32'h0000_001F, 31, 32'h8000_0000);
    run_op("sh4", 32'hFFFF_FFFF, 32'h0000_0004, 4, 32'hFFFF_FFF0);
    run_op("sh0", 32'h1234_5678, 32'h0000_0020, 0, 32'h1234_5678);
    run_op("shhi", 32'h0000_000F, 32'hFFFF_FFE3, 3, 32'h0000_0078);

    // Backpressure in DONE with a competing request pending.
    out_ready = 1'b0;
    start_op(32'h0000_0005, 32'h0000_0001);
    wait_done("bp", 1, 32'h0000_000A);
    in_valid  = 1'b1;
    SrcA      = 32'h0000_0007;
    Immediate = 32'h0000_0002;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_vld", 32'(out_valid), 32'd1);
      check("bp_hold_rd", Rd, 32'h0000_000A);
      check("bp_hold_inrdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_vld", 32'(out_valid), 32'd0);
    check("bp_idle_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    SrcA      = 32'hDEAD_BEEF;
    Immediate = 32'h0000_0009;
    wait_done("bp_next", 2, 32'h0000_001C);
    @(posedge clk);
    @(negedge clk);

    // Flush at acceptance+2 of a long shift; working register keeps one shift.
    start_op(32'h0000_0001, 32'h0000_000A);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("fl_inrdy", 32'(in_ready), 32'd1);
    check("fl_vld", 32'(out_valid), 32'd0);
    check("fl_rd_hold", Rd, 32'h0000_0002);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("fl_no_vld", 32'(seen), 32'd0);
    run_op("fl_next", 32'h0000_0003, 32'h0000_0001, 1, 32'h0000_0006);

    // Asynchronous reset between edges during SHIFT.
    start_op(32'h0000_00FF, 32'h0000_0014);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_inrdy", 32'(in_ready), 32'd1);
    check("ar_vld", 32'(out_valid), 32'd0);
    check("ar_rd", Rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("ar_no_vld", 32'(seen), 32'd0);

    // Request already present when reset releases is taken on the first edge.
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    SrcA      = 32'h0000_0009;
    Immediate = 32'h0000_0000;
    rst_n     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rel_vld", 32'(out_valid), 32'd1);
    check("rel_rd", Rd, 32'h0000_0009);
    @(posedge clk);
    @(negedge clk);
    check("rel_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slli_iterative.md
SLLI_ITERATIVE -- requirements
Module: slli_iterative

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have localparam SHAMT_WIDTH = $clog2(DATA_WIDTH), default 5, giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous pipeline flush that abandons any operation.
REQ-006 The block SHALL have port in_valid, input, 1 bit: SrcA and Immediate carry a request.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port SrcA, input, DATA_WIDTH bits: value to shift.
REQ-009 The block SHALL have port Immediate, input, DATA_WIDTH bits: only bits [SHAMT_WIDTH-1:0] form shamt; upper bits are ignored.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Rd holds a completed result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port Rd, output, DATA_WIDTH bits: logical-left-shift result, zero-filled.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be Moore outputs.
REQ-015 Acceptance SHALL occur on an edge with state IDLE, in_valid=1 and flush=0; that edge loads the working register with SrcA and the counter with shamt.
REQ-016 On acceptance, next state SHALL be DONE if shamt=0, else SHIFT.
REQ-017 In SHIFT, each edge SHALL shift the working register left by 1 with a zero fill and decrement the counter; when the counter was 1, next state is DONE.
REQ-018 out_valid SHALL first be high in the cycle after edge k+shamt, where k is the acceptance edge (shamt=0 gives the cycle after k).
REQ-019 Rd SHALL equal the working register, and SHALL equal SrcA << shamt (mod 2^DATA_WIDTH) whenever out_valid=1.
REQ-020 In DONE, Rd and out_valid SHALL stay stable until an edge with out_ready=1; that edge returns the block to IDLE.
REQ-021 No new request SHALL be accepted in DONE, even when out_ready=1; back-to-back throughput is one result per shamt+2 cycles.
REQ-022 Changes on SrcA or Immediate after acceptance SHALL have no effect on the operation in flight.
REQ-023 flush=1 on any edge SHALL force IDLE, taking priority over acceptance, shifting and the out handshake; the working register holds its value; no out_valid results.
REQ-024 in_valid while not in IDLE SHALL be ignored; the requester holds the request until in_ready=1.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, working register 0, counter 0; outputs are then in_ready=1, out_valid=0, Rd=0.
REQ-026 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation; no out_valid SHALL appear after release until a new acceptance.
REQ-027 After rst_n deasserts, the first edge SHALL already be able to accept a request.

Structure
REQ-028 Package shift_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default DATA_WIDTH/SHAMT_WIDTH constants, for reuse by a future right-shift variant.
REQ-029 A single sub-module shamt_down_counter (load, decrement, is_one flag, SHAMT_WIDTH wide) SHALL hold the counter; the datapath and FSM SHALL stay in slli_iterative.

Verification
REQ-030 A bench SHALL cover: SrcA=0x00000010, Immediate=0x2, out_ready=1 -> out_valid after edge k+2, Rd=0x00000040, IDLE one edge later.
REQ-031 A bench SHALL cover: SrcA=0x00000001, Immediate=0x1F -> Rd=0x80000000 after 31 shift edges; SrcA=0xFFFFFFFF, Immediate=0x4 -> Rd=0xFFFFFFF0.
REQ-032 A bench SHALL cover: SrcA=0x12345678, Immediate=0x20 (shamt=0) -> out_valid in the cycle after acceptance, Rd=0x12345678.
REQ-033 A bench SHALL cover: out_ready=0 for 3 cycles in DONE with in_valid=1 -> Rd and out_valid stable, in_ready=0; out_ready=1 -> IDLE, then the new request is accepted.
REQ-034 A bench SHALL cover: flush=1 at edge k+2 of a shamt=10 request -> IDLE next cycle, out_valid never asserted; a following shamt=1 request on 0x3 -> Rd=0x6.
REQ-035 A bench SHALL cover: rst_n=0 mid-SHIFT between edges -> in_ready=1, out_valid=0, Rd=0 immediately with no clock edge.
